// File: rtl/cv32e40s_zcmp_sequencer_pkg.sv
// Shared types and RV32I opcode constants for the Zcmp micro-op sequencer.
package cv32e40s_zcmp_sequencer_pkg;

  typedef enum logic [2:0] {
    ZcmpPush,
    ZcmpPop,
    ZcmpPopret,
    ZcmpPopretz,
    ZcmpMvsa01,
    ZcmpMva01s
  } zcmp_op_e;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } seq_state_e;

  localparam logic [6:0] OPCODE_STORE = 7'h23;
  localparam logic [6:0] OPCODE_LOAD  = 7'h03;
  localparam logic [6:0] OPCODE_OPIMM = 7'h13;
  localparam logic [6:0] OPCODE_JALR  = 7'h67;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_ADDI = 3'b000;

endpackage

// File: rtl/cv32e40s_zcmp_sequencer.sv
// Expands Zcmp push/pop/popret/popretz/mvsa01/mva01s into a stream of RV32I micro-ops,
// one per decoder handshake, with the first micro-op available combinationally.
module cv32e40s_zcmp_sequencer
  import cv32e40s_zcmp_sequencer_pkg::*;
#(
  parameter bit ZCMP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic        kill_i,
  output logic        match_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic        first_op_o,
  output logic        last_op_o
);

  localparam logic [4:0] RegX0 = 5'd0;
  localparam logic [4:0] RegRa = 5'd1;
  localparam logic [4:0] RegSp = 5'd2;
  localparam logic [4:0] RegA0 = 5'd10;
  localparam logic [4:0] RegA1 = 5'd11;

  function automatic logic [3:0] rlist_to_n(input logic [3:0] rlist);
    return (rlist == 4'd15) ? 4'd13 : rlist - 4'd3;
  endfunction

  function automatic logic [11:0] rlist_to_base(input logic [3:0] rlist);
    if (rlist <= 4'd7)       return 12'd16;
    else if (rlist <= 4'd11) return 12'd32;
    else if (rlist <= 4'd14) return 12'd48;
    else                     return 12'd64;
  endfunction

  function automatic logic [4:0] list_to_reg(input logic [3:0] j);
    case (j)
      4'd0:    return 5'd1;
      4'd1:    return 5'd8;
      4'd2:    return 5'd9;
      default: return {1'b0, j} + 5'd15;
    endcase
  endfunction

  // s0/s1 are x8/x9, s2..s7 are x18..x23
  function automatic logic [4:0] s_reg(input logic [2:0] r);
    return (r[2:1] == 2'b00) ? {4'b0100, r[0]} : {2'b10, r};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  seq_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [15:0] c_instr;
  logic [3:0]  rlist;
  logic [1:0]  spimm;
  logic [2:0]  r1s, r2s;
  zcmp_op_e    op;
  logic        op_known;
  logic        op_legal;
  logic [4:0]  n_ops;
  logic [3:0]  n_regs;
  logic [11:0] adj;
  logic [11:0] off;
  logic [4:0]  lreg;
  logic [3:0]  tail_idx;
  logic [31:0] uop;
  logic        handshake;
  logic        unused_instr_hi;

  assign c_instr         = instr_i[15:0];
  assign unused_instr_hi = ^instr_i[31:16];
  assign rlist           = c_instr[7:4];
  assign spimm           = c_instr[3:2];
  assign r1s             = c_instr[9:7];
  assign r2s             = c_instr[4:2];

  always_comb begin
    op       = ZcmpPush;
    op_known = 1'b0;
    if (c_instr[1:0] == 2'b10 && c_instr[15:13] == 3'b101) begin
      case (c_instr[12:8])
        5'b11000: begin op = ZcmpPush;    op_known = 1'b1; end
        5'b11010: begin op = ZcmpPop;     op_known = 1'b1; end
        5'b11100: begin op = ZcmpPopretz; op_known = 1'b1; end
        5'b11110: begin op = ZcmpPopret;  op_known = 1'b1; end
        default: begin
          if (c_instr[12:10] == 3'b011) begin
            if (c_instr[6:5] == 2'b01) begin
              op       = ZcmpMvsa01;
              op_known = 1'b1;
            end else if (c_instr[6:5] == 2'b11) begin
              op       = ZcmpMva01s;
              op_known = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    n_regs = rlist_to_n(rlist);
    case (op)
      ZcmpMvsa01: op_legal = (r1s != r2s);
      ZcmpMva01s: op_legal = 1'b1;
      default:    op_legal = (rlist >= 4'd4);
    endcase
    case (op)
      ZcmpPopret:              n_ops = {1'b0, n_regs} + 5'd2;
      ZcmpPopretz:             n_ops = {1'b0, n_regs} + 5'd3;
      ZcmpMvsa01, ZcmpMva01s:  n_ops = 5'd2;
      default:                 n_ops = {1'b0, n_regs} + 5'd1;
    endcase
  end

  // Micro-op k: register transfers first (highest list index first), then the tail ops.
  always_comb begin
    adj      = rlist_to_base(rlist) + {6'd0, spimm, 4'd0};
    off      = {6'd0, cnt_q + 4'd1, 2'b00};
    lreg     = list_to_reg(n_regs - 4'd1 - cnt_q);
    tail_idx = cnt_q - n_regs;
    uop      = 32'h0;
    case (op)
      ZcmpPush: begin
        if (cnt_q < n_regs) uop = enc_s(12'd0 - off, lreg, RegSp, F3_WORD, OPCODE_STORE);
        else                uop = enc_i(12'd0 - adj, RegSp, F3_ADDI, RegSp, OPCODE_OPIMM);
      end
      ZcmpPop, ZcmpPopret, ZcmpPopretz: begin
        if (cnt_q < n_regs) begin
          uop = enc_i(adj - off, RegSp, F3_WORD, lreg, OPCODE_LOAD);
        end else if (op == ZcmpPopretz && tail_idx == 4'd0) begin
          uop = enc_i(12'd0, RegX0, F3_ADDI, RegA0, OPCODE_OPIMM);
        end else if ((op == ZcmpPopretz && tail_idx == 4'd1) || tail_idx == 4'd0) begin
          uop = enc_i(adj, RegSp, F3_ADDI, RegSp, OPCODE_OPIMM);
        end else begin
          uop = enc_i(12'd0, RegRa, F3_ADDI, RegX0, OPCODE_JALR);
        end
      end
      ZcmpMvsa01: begin
        if (cnt_q == 4'd0) uop = enc_i(12'd0, RegA0, F3_ADDI, s_reg(r1s), OPCODE_OPIMM);
        else               uop = enc_i(12'd0, RegA1, F3_ADDI, s_reg(r2s), OPCODE_OPIMM);
      end
      ZcmpMva01s: begin
        if (cnt_q == 4'd0) uop = enc_i(12'd0, s_reg(r1s), F3_ADDI, RegA0, OPCODE_OPIMM);
        else               uop = enc_i(12'd0, s_reg(r2s), F3_ADDI, RegA1, OPCODE_OPIMM);
      end
      default: uop = 32'h0;
    endcase
  end

  // Output process
  always_comb begin
    match_o       = ZCMP_EN && instr_valid_i && op_known && op_legal;
    instr_o       = match_o ? uop : 32'h0;
    instr_valid_o = match_o && !kill_i;
    first_op_o    = (cnt_q == 4'd0);
    last_op_o     = match_o && ({1'b0, cnt_q} == n_ops - 5'd1);
    handshake     = instr_valid_o && instr_ready_i;
    instr_ready_o = handshake && last_op_o;
  end

  // Next-state process; kill_i takes priority over a simultaneous handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (kill_i) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
    end else if (handshake && last_op_o) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
    end else if (handshake) begin
      state_d = StActive;
      cnt_d   = (state_q == StIdle) ? 4'd1 : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The instruction must stay presented until its last micro-op is accepted or killed.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (state_q == StActive) |-> (instr_valid_i || kill_i));

endmodule

// File: tb/tb_cv32e40s_zcmp_sequencer.sv
// Directed, table-driven bench for the Zcmp sequencer with hand-computed micro-op encodings.
module tb_cv32e40s_zcmp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_i = 32'h0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic        kill_i = 1'b0;
  logic        match_o;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic        first_op_o;
  logic        last_op_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cv32e40s_zcmp_sequencer #(.ZCMP_EN(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_i      (instr_i),
    .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o),
    .kill_i       (kill_i),
    .match_o      (match_o),
    .instr_o      (instr_o),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .first_op_o   (first_op_o),
    .last_op_o    (last_op_o)
  );

  typedef struct {
    logic [15:0] ci;
    logic        vi;
    logic        ri;
    logic        ki;
    logic        ev;
    logic [31:0] eo;
    logic        ef;
    logic        el;
    logic        er;
    logic        em;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_op(input logic [15:0] ci, input logic ri, input logic ki,
                                 input logic [31:0] eo, input logic ef, input logic el);
    vec_t v;
    v.ci = ci; v.vi = 1'b1; v.ri = ri; v.ki = ki;
    v.ev = !ki; v.eo = eo; v.ef = ef; v.el = el;
    v.er = ri && el && !ki; v.em = 1'b1;
    vecs.push_back(v);
  endfunction

  function automatic void add_nm(input logic [15:0] ci, input logic vi);
    vec_t v;
    v.ci = ci; v.vi = vi; v.ri = 1'b1; v.ki = 1'b0;
    v.ev = 1'b0; v.eo = 32'h0; v.ef = 1'b1; v.el = 1'b0; v.er = 1'b0; v.em = 1'b0;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  logic [31:0] ops[16];
  int          nv;
  bit          done;

  initial begin
    // idle and illegal encodings
    add_nm(16'hB87E, 1'b0);
    add_nm(16'hAC22, 1'b1);
    add_nm(16'hBA22, 1'b1);
    // cm.push {ra,s0-s2},-64
    add_op(16'hB87E, 1, 0, 32'hFF212E23, 1, 0);
    add_op(16'hB87E, 1, 0, 32'hFE912C23, 0, 0);
    add_op(16'hB87E, 1, 0, 32'hFE812A23, 0, 0);
    add_op(16'hB87E, 1, 0, 32'hFE112823, 0, 0);
    add_op(16'hB87E, 1, 0, 32'hFC010113, 0, 1);
    // cm.popretz {ra},16
    add_op(16'hBC42, 1, 0, 32'h00C12083, 1, 0);
    add_op(16'hBC42, 1, 0, 32'h00000513, 0, 0);
    add_op(16'hBC42, 1, 0, 32'h01010113, 0, 0);
    add_op(16'hBC42, 1, 0, 32'h00008067, 0, 1);
    // cm.mvsa01 s0,s1 and cm.mva01s s0,s1
    add_op(16'hAC26, 1, 0, 32'h00050413, 1, 0);
    add_op(16'hAC26, 1, 0, 32'h00058493, 0, 1);
    add_op(16'hAC66, 1, 0, 32'h00040513, 1, 0);
    add_op(16'hAC66, 1, 0, 32'h00048593, 0, 1);
    // push with backpressure on op 2
    add_op(16'hB87E, 1, 0, 32'hFF212E23, 1, 0);
    for (int k = 0; k < 3; k++) add_op(16'hB87E, 0, 0, 32'hFE912C23, 0, 0);
    add_op(16'hB87E, 1, 0, 32'hFE912C23, 0, 0);
    add_op(16'hB87E, 1, 0, 32'hFE812A23, 0, 0);
    add_op(16'hB87E, 1, 0, 32'hFE112823, 0, 0);
    add_op(16'hB87E, 1, 0, 32'hFC010113, 0, 1);
    // push killed on op 3, then restarted from op 0
    add_op(16'hB87E, 1, 0, 32'hFF212E23, 1, 0);
    add_op(16'hB87E, 1, 0, 32'hFE912C23, 0, 0);
    add_op(16'hB87E, 1, 1, 32'hFE812A23, 0, 0);
    add_op(16'hB87E, 1, 0, 32'hFF212E23, 1, 0);
    add_op(16'hB87E, 1, 0, 32'hFE912C23, 0, 0);
    add_op(16'hB87E, 1, 0, 32'hFE812A23, 0, 0);
    add_op(16'hB87E, 1, 0, 32'hFE112823, 0, 0);
    add_op(16'hB87E, 1, 0, 32'hFC010113, 0, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset valid", {31'd0, instr_valid_o}, 32'd0);
    check("reset match", {31'd0, match_o}, 32'd0);
    check("reset ready", {31'd0, instr_ready_o}, 32'd0);
    check("reset first", {31'd0, first_op_o}, 32'd1);
    check("reset instr", instr_o, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      instr_i       = {16'h0, vecs[i].ci};
      instr_valid_i = vecs[i].vi;
      instr_ready_i = vecs[i].ri;
      kill_i        = vecs[i].ki;
      #1;
      check($sformatf("row%0d valid", i), {31'd0, instr_valid_o}, {31'd0, vecs[i].ev});
      check($sformatf("row%0d instr", i), instr_o, vecs[i].eo);
      check($sformatf("row%0d first", i), {31'd0, first_op_o}, {31'd0, vecs[i].ef});
      check($sformatf("row%0d last", i), {31'd0, last_op_o}, {31'd0, vecs[i].el});
      check($sformatf("row%0d iready", i), {31'd0, instr_ready_o}, {31'd0, vecs[i].er});
      check($sformatf("row%0d match", i), {31'd0, match_o}, {31'd0, vecs[i].em});
    end

    // cm.popret {ra,s0-s11},112: longest sequence, 15 micro-ops
    @(negedge clk);
    instr_i = {16'h0, 16'hBEFE};
    instr_valid_i = 1'b1;
    instr_ready_i = 1'b1;
    kill_i = 1'b0;
    nv = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (instr_valid_o) begin
        if (nv < 16) ops[nv] = instr_o;
        nv++;
      end
      if (instr_ready_o) done = 1'b1;
      @(negedge clk);
    end
    instr_valid_i = 1'b0;
    check("popret done", {31'd0, done}, 32'd1);
    check("popret count", nv, 15);
    check("popret op0", ops[0], 32'h06C12D83);
    check("popret op13", ops[13], 32'h07010113);
    check("popret op14", ops[14], 32'h00008067);

    // cm.pop {ra,s0-s1},16 with reset asserted on op 2
    instr_i = {16'h0, 16'hBA62};
    instr_valid_i = 1'b1;
    instr_ready_i = 1'b1;
    #1;
    check("pop op0", instr_o, 32'h00C12483);
    check("pop op0 first", {31'd0, first_op_o}, 32'd1);
    @(negedge clk);
    #1;
    check("pop op1", instr_o, 32'h00812403);
    check("pop op1 first", {31'd0, first_op_o}, 32'd0);
    instr_ready_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    instr_ready_i = 1'b1;
    #1;
    check("pop rst first", {31'd0, first_op_o}, 32'd1);
    check("pop rst instr", instr_o, 32'h00C12483);
    check("pop rst valid", {31'd0, instr_valid_o}, 32'd1);
    nv = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (c != 0) #1;
      if (instr_valid_o) nv++;
      if (instr_ready_o) done = 1'b1;
      @(negedge clk);
    end
    instr_valid_i = 1'b0;
    check("pop rst done", {31'd0, done}, 32'd1);
    check("pop rst count", nv, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
